// File: rtl/universal_reg_pkg.sv
// -----------------------------------------------------------------------------
// universal_reg_pkg
//   Shared definitions for the universal register slice.
//   mode_t : 3-bit operation select driven onto universal_reg.mode
// -----------------------------------------------------------------------------
package universal_reg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROTL = 3'b100,
      MODE_ROTR = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_t;

endpackage

// File: rtl/dff_cell.sv
// -----------------------------------------------------------------------------
// dff_cell
//   Single-bit rising-edge flop with asynchronous active-low clear and set.
//   Clear dominates set.
//   D    in  data captured on rising C
//   C    in  clock
//   nP   in  async set, active low
//   nR   in  async clear, active low (wins over nP)
//   Q    out stored bit
//   Qbar out ~Q
// -----------------------------------------------------------------------------
module dff_cell (
   input  logic D,
   input  logic C,
   input  logic nP,
   input  logic nR,
   output logic Q,
   output logic Qbar
);

   always_ff @(posedge C or negedge nR or negedge nP) begin
      if (!nR) begin
         Q <= 1'b0;
      end else if (!nP) begin
         Q <= 1'b1;
      end else begin
         Q <= D;
      end
   end

   assign Qbar = ~Q;

endmodule

// File: rtl/universal_reg.sv
// -----------------------------------------------------------------------------
// universal_reg
//   WIDTH-bit register built from dff_cell instances, with async reset/preset,
//   clock enable, parallel load, shift, rotate and up/down count modes.
//   C      in  clock, rising edge
//   nR     in  async reset, active low -> Q = RESET_VAL, co = 0
//   nP     in  async preset, active low -> Q = PRESET_VAL, co = 0 (nR wins)
//   en     in  synchronous enable; 0 holds Q and co
//   mode   in  operation select (universal_reg_pkg::mode_t)
//   D      in  parallel load data
//   sl_in  in  serial input for SHL, enters bit 0
//   sr_in  in  serial input for SHR, enters bit WIDTH-1
//   Q      out register contents
//   Qbar   out exact complement of Q
//   co     out registered count-wrap flag
//   zero   out combinational, 1 when Q == 0
// -----------------------------------------------------------------------------
module universal_reg
   import universal_reg_pkg::*;
#(
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
   input  logic             C,
   input  logic             nR,
   input  logic             nP,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             sl_in,
   input  logic             sr_in,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             co,
   output logic             zero
);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] d_bits;
   logic [WIDTH-1:0] clr_n;
   logic [WIDTH-1:0] set_n;
   logic             wrap;
   logic             co_d;
   logic             co_q;
   logic             co_bar;
   logic             co_clr_n;

   // Shifts/rotates are written as whole-word shifts so WIDTH=1 falls out
   // naturally: SHL/SHR take the serial input, ROTL/ROTR hold.
   // Unused inputs (D, sl_in, sr_in) only reach nxt in their own mode.
   always_comb begin
      nxt  = Q;
      wrap = 1'b0;
      case (mode_t'(mode))
         MODE_HOLD: nxt = Q;
         MODE_LOAD: nxt = D;
         MODE_SHL:  nxt = (Q << 1) | WIDTH'(sl_in);
         MODE_SHR:  nxt = (Q >> 1) | (WIDTH'(sr_in) << (WIDTH - 1));
         MODE_ROTL: nxt = (Q << 1) | (Q >> (WIDTH - 1));
         MODE_ROTR: nxt = (Q >> 1) | (Q << (WIDTH - 1));
         MODE_INC: begin
            nxt  = Q + WIDTH'(1);
            wrap = (Q == '1);
         end
         MODE_DEC: begin
            nxt  = Q - WIDTH'(1);
            wrap = (Q == '0);
         end
         default: nxt = Q;
      endcase
      d_bits = en ? nxt : Q;
      co_d   = en ? wrap : co_q;
   end

   // Per-bit async controls: each bit is either cleared or set, never both,
   // so release of nR while nP is still low produces a falling edge on the
   // set input of every bit that must move to PRESET_VAL.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign clr_n[i] = !((!nR && !RESET_VAL[i]) || (nR && !nP && !PRESET_VAL[i]));
      assign set_n[i] = !((!nR &&  RESET_VAL[i]) || (nR && !nP &&  PRESET_VAL[i]));

      dff_cell u_cell (
         .D    (d_bits[i]),
         .C    (C),
         .nP   (set_n[i]),
         .nR   (clr_n[i]),
         .Q    (Q[i]),
         .Qbar (Qbar[i])
      );
   end

   assign co_clr_n = nR && nP;

   dff_cell u_co (
      .D    (co_d),
      .C    (C),
      .nP   (1'b1),
      .nR   (co_clr_n),
      .Q    (co_q),
      .Qbar (co_bar)
   );

   // Output taken from the complement pin; feedback from the true pin.
   assign co   = ~co_bar;
   assign zero = (Q == '0);

endmodule

// File: tb/tb_universal_reg.sv
module tb_universal_reg;
   import universal_reg_pkg::*;

   logic       C = 1'b0;
   always #5 C = ~C;

   // WIDTH=8 instance
   logic       nR, nP, en, sl_in, sr_in;
   logic [2:0] mode;
   logic [7:0] D, Q, Qbar;
   logic       co, zero;

   // WIDTH=1 instance
   logic       nR1, nP1, en1, sl1, sr1;
   logic [2:0] mode1;
   logic [0:0] D1, Q1, Qb1;
   logic       co1, z1;

   int tests = 0;
   int fails = 0;

   universal_reg #(.WIDTH(8)) dut (
      .C(C), .nR(nR), .nP(nP), .en(en), .mode(mode), .D(D),
      .sl_in(sl_in), .sr_in(sr_in), .Q(Q), .Qbar(Qbar), .co(co), .zero(zero)
   );

   universal_reg #(.WIDTH(1)) dut1 (
      .C(C), .nR(nR1), .nP(nP1), .en(en1), .mode(mode1), .D(D1),
      .sl_in(sl1), .sr_in(sr1), .Q(Q1), .Qbar(Qb1), .co(co1), .zero(z1)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic load8(input logic [7:0] v);
      en = 1'b1; mode = MODE_LOAD; D = v;
      tick();
   endtask

   initial begin
      nR = 1'b0; nP = 1'b1; en = 1'b0; mode = MODE_HOLD; D = '0;
      sl_in = 1'b0; sr_in = 1'b0;
      nR1 = 1'b0; nP1 = 1'b1; en1 = 1'b0; mode1 = MODE_HOLD; D1 = '0;
      sl1 = 1'b0; sr1 = 1'b0;

      #3;
      check("rst_q",    Q,    8'h00);
      check("rst_qbar", Qbar, 8'hFF);
      check("rst_co",   {7'd0, co},   8'h00);
      check("rst_zero", {7'd0, zero}, 8'h01);
      check("w1_rst_q", {7'd0, Q1},   8'h00);
      nR = 1'b1;

      // 1: async reset between edges
      load8(8'hA5);
      check("load_a5", Q, 8'hA5);
      #2 nR = 1'b0;
      #1;
      check("async_rst_q",    Q,    8'h00);
      check("async_rst_qbar", Qbar, 8'hFF);
      check("async_rst_co",   {7'd0, co}, 8'h00);
      nP = 1'b0;
      #1 check("rst_and_preset", Q, 8'h00);
      nR = 1'b1;
      #1 check("preset_after_rst_release", Q, 8'hFF);

      // 2: preset release then load
      nP = 1'b1;
      #1 check("preset_held", Q, 8'hFF);
      load8(8'h3C);
      check("load_3c",      Q,    8'h3C);
      check("load_3c_qbar", Qbar, 8'hC3);
      check("load_3c_zero", {7'd0, zero}, 8'h00);

      // 3: shifts and rotates, each from 0x81
      load8(8'h81);
      mode = MODE_SHL; sl_in = 1'b1; tick();
      check("shl", Q, 8'h03);
      sl_in = 1'b0;
      load8(8'h81);
      mode = MODE_SHR; sr_in = 1'b0; tick();
      check("shr", Q, 8'h40);
      load8(8'h81);
      mode = MODE_SHR; sr_in = 1'b1; tick();
      check("shr_in1", Q, 8'hC0);
      load8(8'h81);
      mode = MODE_ROTL; tick();
      check("rotl", Q, 8'h03);
      load8(8'h81);
      mode = MODE_ROTR; tick();
      check("rotr", Q, 8'hC0);

      // unused inputs undriven must not corrupt INC
      D = 'x; sl_in = 1'bx; sr_in = 1'bx; mode = MODE_INC; tick();
      check("inc_x_inputs", Q, 8'hC1);
      sl_in = 1'b0; sr_in = 1'b0;

      // 4: wrap flag
      load8(8'hFF);
      check("co_before_wrap", {7'd0, co}, 8'h00);
      mode = MODE_INC; tick();
      check("inc_wrap_q",    Q, 8'h00);
      check("inc_wrap_co",   {7'd0, co},   8'h01);
      check("inc_wrap_zero", {7'd0, zero}, 8'h01);
      tick();
      check("inc_q", Q, 8'h01);
      check("inc_co_clear", {7'd0, co}, 8'h00);
      load8(8'h00);
      mode = MODE_DEC; tick();
      check("dec_wrap_q",  Q, 8'hFF);
      check("dec_wrap_co", {7'd0, co}, 8'h01);

      // 5: enable low holds Q and co
      en = 1'b0; mode = MODE_LOAD; D = 8'h55;
      tick(); tick(); tick();
      check("en0_q",  Q, 8'hFF);
      check("en0_co", {7'd0, co}, 8'h01);

      // preset clears co
      nP = 1'b0;
      #1;
      check("preset_q",  Q, 8'hFF);
      check("preset_co", {7'd0, co}, 8'h00);
      nP = 1'b1;

      // WIDTH=1 build
      nR1 = 1'b1; en1 = 1'b1; mode1 = MODE_INC;
      tick();
      check("w1_inc_q",  {7'd0, Q1},  8'h01);
      check("w1_inc_co", {7'd0, co1}, 8'h00);
      tick();
      check("w1_wrap_q",    {7'd0, Q1},  8'h00);
      check("w1_wrap_co",   {7'd0, co1}, 8'h01);
      check("w1_wrap_zero", {7'd0, z1},  8'h01);
      mode1 = MODE_SHL; sl1 = 1'b1; tick();
      check("w1_shl",    {7'd0, Q1},  8'h01);
      check("w1_shl_co", {7'd0, co1}, 8'h00);
      mode1 = MODE_ROTL; tick();
      check("w1_rotl", {7'd0, Q1}, 8'h01);
      mode1 = MODE_SHR; sr1 = 1'b0; tick();
      check("w1_shr", {7'd0, Q1}, 8'h00);
      mode1 = MODE_DEC; tick();
      check("w1_dec_q",  {7'd0, Q1},  8'h01);
      check("w1_dec_co", {7'd0, co1}, 8'h01);

      // 6: async reset during counting
      load8(8'h10);
      mode = MODE_INC; tick();
      check("run_inc", Q, 8'h11);
      #2 nR = 1'b0;
      #1 check("mid_rst_q", Q, 8'h00);
      nR = 1'b1;
      #1 check("mid_rst_release", Q, 8'h00);
      tick();
      check("post_rst_inc", Q, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
